acc_cpu_core: RTL and testbench
===============================

ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter DATA_W, 8, accumulator / I/O data width (>=2).
REQ-002 Parameter PC_W, 4, program counter width; program memory depth = 2**PC_W words.
REQ-003 Instruction word width = 3+PC_W: opcode = bits [PC_W+2:PC_W], operand = bits [PC_W-1:0].
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  single-cycle pulse; leaves HALT and begins execution at PC=0.
REQ-007 prog_we  input  1  program memory write enable.
REQ-008 prog_addr  input  PC_W  program memory write address.
REQ-009 prog_data  input  3+PC_W  program memory write data.
REQ-010 in_data  input  DATA_W  input operand.
REQ-011 in_valid  input  1  in_data valid.
REQ-012 in_ready  output  1  core accepting in_data.
REQ-013 out_data  output  DATA_W  registered output value.
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_ready  input  1  consumer accepts out_data.
REQ-016 zero  output  1  combinational (A == 0).
REQ-017 halted  output  1  high while in HALT state.
REQ-018 pc  output  PC_W  current program counter (debug).

Function
REQ-019 FSM states HALT, FETCH, DECODE, EXECUTE; HALT->FETCH on start; FETCH->DECODE->EXECUTE unconditionally; EXECUTE->FETCH on completion, ->HALT on opcode HALT.
REQ-020 FETCH: IR <= mem[PC], PC <= PC+1 modulo 2**PC_W (wrap from all-ones to 0).
REQ-021 DECODE: no architectural state change; one-cycle register stage only.
REQ-022 Opcodes: 000 IN, 001 OUT, 010 DEC, 011 INC, 100 JNZ, 101 JMP, 110 LDI, 111 HALT.
REQ-023 IN: in_ready high only in EXECUTE of IN; A <= in_data and completion on the cycle in_valid && in_ready; otherwise remain in EXECUTE.
REQ-024 OUT: on entering EXECUTE, out_data <= A and out_valid <= 1; completion on the cycle out_valid && out_ready; out_valid then deasserts; out_data holds last value.
REQ-025 DEC: A <= A-1 modulo 2**DATA_W (0 -> all-ones); INC: A <= A+1 (all-ones -> 0); one EXECUTE cycle.
REQ-026 JNZ: if A != 0 then PC <= operand, else PC unchanged; JMP: PC <= operand unconditionally; one cycle.
REQ-027 LDI: A <= operand zero-extended to DATA_W (truncated to low DATA_W bits if PC_W > DATA_W).
REQ-028 Non-stalling instruction latency = 3 cycles (FETCH+DECODE+EXECUTE).
REQ-029 prog_we honoured only in HALT; ignored in all other states.
REQ-030 start ignored outside HALT; start and prog_we in the same HALT cycle: write performed and FETCH entered.
REQ-031 in_valid while in_ready low, and out_ready while out_valid low, have no effect.

Reset
REQ-032 Reset forces state HALT, PC=0, IR=0, A=0, out_data=0, out_valid=0, in_ready=0, halted=1 immediately, independent of clk.
REQ-033 Reset does not clear program memory; reset mid-instruction (including stalled IN/OUT) abandons it without completion.

Structure
REQ-034 Opcode constants and FSM state encodings live in shared package acc_cpu_pkg.
REQ-035 Program memory is sub-module acc_prog_mem (synchronous write, asynchronous read, parameterised by PC_W).

Verification
REQ-036 Reset mid-EXECUTE of OUT -> out_valid=0, halted=1, pc=0 without clk edge.
REQ-037 Load {IN, OUT, DEC, JNZ 1, HALT}, start, in_data=3 -> outputs 3,2,1 in order, then halted=1, A=0.
REQ-038 out_ready held low 10 cycles during OUT -> out_valid stays 1, out_data stable, pc unchanged until out_ready.
REQ-039 LDI 0, DEC -> A=all-ones (8'hFF default), zero=0; INC -> A=0, zero=1.
REQ-040 JMP 15 at PC_W=4, mem[15]=INC, mem[0]=HALT -> PC wraps 15->0, halts with A incremented by 1.
REQ-041 prog_we pulse during FETCH -> memory unchanged (readback after HALT confirms).

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - opcode and FSM state encodings shared by the accumulator core
package acc_cpu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_IN   = 3'b000,
        OP_OUT  = 3'b001,
        OP_DEC  = 3'b010,
        OP_INC  = 3'b011,
        OP_JNZ  = 3'b100,
        OP_JMP  = 3'b101,
        OP_LDI  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_HALT    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DECODE  = 2'd2,
        ST_EXECUTE = 2'd3
    } state_e;

endpackage

// File: rtl/acc_cpu_core_if.sv
// rtl/acc_cpu_core_if.sv - input and output handshake streams of the accumulator core
interface acc_cpu_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // environment side: produces input operands, consumes results
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // core side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/acc_prog_mem.sv
// rtl/acc_prog_mem.sv - program memory, synchronous write and asynchronous read
module acc_prog_mem #(
    parameter int PC_W   = 4,
    parameter int WORD_W = 3 + PC_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PC_W-1:0]   i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [PC_W-1:0]   i_raddr,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [2**PC_W];

    // contents survive core reset, so the array has no reset term
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - multi-cycle accumulator CPU with stream input/output
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_W-1:0]        prog_addr,
    input  logic [OPCODE_W+PC_W-1:0] prog_data,
    acc_cpu_core_if.slave          io,
    output logic                   zero,
    output logic                   halted,
    output logic [PC_W-1:0]        pc
);
    localparam int IR_W = OPCODE_W + PC_W;

    state_e            r_state;
    state_e            w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [IR_W-1:0]   r_ir;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic              w_mem_we;
    logic [IR_W-1:0]   w_mem_rdata;
    opcode_e           w_opcode;
    logic [PC_W-1:0]   w_operand;
    logic [DATA_W-1:0] w_imm;
    logic              w_in_ready;
    logic              w_done;

    // the program may only be rewritten while the core is parked
    assign w_mem_we = prog_we && (r_state == ST_HALT);

    acc_prog_mem #(
        .PC_W   (PC_W),
        .WORD_W (IR_W)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rdata)
    );

    assign w_opcode  = opcode_e'(r_ir[IR_W-1:PC_W]);
    assign w_operand = r_ir[PC_W-1:0];

    // LDI immediate: zero-extend a narrow operand, keep the low bits of a wide one
    generate
        if (PC_W >= DATA_W) begin : g_imm_trunc
            assign w_imm = w_operand[DATA_W-1:0];
        end else begin : g_imm_ext
            assign w_imm = {{(DATA_W-PC_W){1'b0}}, w_operand};
        end
    endgenerate

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next state, input handshake and instruction completion
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_HALT:   if (start) w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = ST_EXECUTE;
            ST_EXECUTE: begin
                case (w_opcode)
                    OP_IN: begin
                        w_in_ready = 1'b1;
                        w_done     = io.in_valid;
                    end
                    OP_OUT:  w_done = r_out_valid && io.out_ready;
                    OP_HALT: w_state_next = ST_HALT;
                    default: w_done = 1'b1;
                endcase
                if (w_done) w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_HALT;
        endcase
    end

    // architectural state: PC, IR, accumulator and the output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_HALT: if (start) r_pc <= '0;
                ST_FETCH: begin
                    r_ir <= w_mem_rdata;
                    r_pc <= r_pc + 1'b1;
                end
                ST_DECODE: begin
                    // present the result as EXECUTE of OUT begins
                    if (w_opcode == OP_OUT) begin
                        r_out_data  <= r_acc;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    case (w_opcode)
                        OP_IN:  if (io.in_valid) r_acc <= io.in_data;
                        OP_OUT: if (io.out_ready) r_out_valid <= 1'b0;
                        OP_DEC: r_acc <= r_acc - 1'b1;
                        OP_INC: r_acc <= r_acc + 1'b1;
                        OP_JNZ: if (r_acc != '0) r_pc <= w_operand;
                        OP_JMP: r_pc <= w_operand;
                        OP_LDI: r_acc <= w_imm;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = w_in_ready;
    assign io.out_data  = r_out_data;
    assign io.out_valid = r_out_valid;
    assign zero         = (r_acc == '0);
    assign halted       = (r_state == ST_HALT);
    assign pc           = r_pc;
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb/tb_acc_cpu_core.sv - randomized bench for acc_cpu_core against an instruction-level model
module tb_acc_cpu_core;
    localparam int DATA_W = 8;
    localparam int PC_W   = 4;
    localparam int DEPTH  = 16;

    localparam logic [2:0] I_IN = 3'd0, I_OUT = 3'd1, I_DEC = 3'd2, I_INC = 3'd3;
    localparam logic [2:0] I_JNZ = 3'd4, I_JMP = 3'd5, I_LDI = 3'd6, I_HALT = 3'd7;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            prog_we = 1'b0;
    logic [PC_W-1:0] prog_addr = '0;
    logic [6:0]      prog_data = '0;
    logic            zero;
    logic            halted;
    logic [PC_W-1:0] pc;

    acc_cpu_core_if #(.DATA_W(DATA_W)) bus ();

    acc_cpu_core #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .io        (bus),
        .zero      (zero),
        .halted    (halted),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] prog    [DEPTH];
    logic [7:0] in_list [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [2:0] op, input logic [3:0] opd);
        return {op, opd};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = enc(I_HALT, 4'd0);
        for (int i = 0; i < DEPTH; i++) in_list[i] = 8'($urandom);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq({tag, ":rst_halted"}, halted, 1);
        check_eq({tag, ":rst_pc"}, pc, 0);
        check_eq({tag, ":rst_out_valid"}, bus.out_valid, 0);
        check_eq({tag, ":rst_in_ready"}, bus.in_ready, 0);
        check_eq({tag, ":rst_zero"}, zero, 1);
        check_eq({tag, ":rst_out_data"}, bus.out_data, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs prog[] from reset state (A=0, PC=0) and compares against the interpreter.
    task automatic run_prog(input string tag, input bit do_load, input bit glitch, input bit rand_hs);
        logic [7:0] a;
        logic [7:0] exp_q[$];
        logic [7:0] last_out;
        logic [6:0] w;
        int mpc, k, exp_n, got_n, in_idx, n;
        bit done, have_last;
        a = 8'd0; mpc = 0; k = 0; done = 0;
        for (int step = 0; step < 64 && !done; step++) begin
            w   = prog[mpc];
            mpc = (mpc + 1) % DEPTH;
            case (w[6:4])
                I_IN:   begin a = in_list[k]; k++; end
                I_OUT:  exp_q.push_back(a);
                I_DEC:  a = 8'((int'(a) + 255) % 256);
                I_INC:  a = 8'((int'(a) + 1) % 256);
                I_JNZ:  if (a != 0) mpc = int'(w[3:0]);
                I_JMP:  mpc = int'(w[3:0]);
                I_LDI:  a = {4'd0, w[3:0]};
                default: done = 1;
            endcase
        end
        exp_n = exp_q.size();
        have_last = (exp_n > 0);
        last_out  = have_last ? exp_q[exp_n-1] : 8'd0;

        if (do_load) load_prog();
        pulse_start();
        if (glitch) begin
            prog_we = 1'b1; prog_addr = 4'd1; prog_data = enc(I_LDI, 4'd7);
        end
        got_n = 0; in_idx = 0; n = 0; done = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            prog_we         = 1'b0;
            bus.in_valid    = rand_hs ? 1'($urandom) : 1'b1;
            bus.out_ready   = rand_hs ? 1'($urandom) : 1'b1;
            bus.in_data     = in_list[in_idx % DEPTH];
            #1;
            if (halted) begin
                done = 1;
            end else begin
                if (bus.in_valid && bus.in_ready) in_idx++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() > 0) check_eq({tag, ":out"}, bus.out_data, exp_q.pop_front());
                    else check_eq({tag, ":extra_out"}, 1, 0);
                    got_n++;
                end
            end
            n++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check_eq({tag, ":halt_reached"}, done, 1);
        check_eq({tag, ":n_out"}, got_n, exp_n);
        check_eq({tag, ":n_in"}, in_idx, k);
        check_eq({tag, ":zero"}, zero, (a == 0));
        check_eq({tag, ":pc"}, pc, mpc);
        if (have_last) check_eq({tag, ":out_hold"}, bus.out_data, last_out);
    endtask

    initial begin
        int n;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset values
        do_reset("init");

        // non-stalling latency: four instructions take 12 cycles
        clear_prog();
        prog[0] = enc(I_LDI, 4'd1); prog[1] = enc(I_INC, 0); prog[2] = enc(I_INC, 0);
        load_prog();
        pulse_start();
        n = 0;
        while (!halted && n < 100) begin @(negedge clk); #1; n++; end
        check_eq("latency", n, 12);
        check_eq("latency:pc", pc, 4);
        check_eq("latency:zero", zero, 0);

        // countdown loop 3,2,1
        do_reset("cnt");
        clear_prog();
        prog[0] = enc(I_IN, 0); prog[1] = enc(I_OUT, 0); prog[2] = enc(I_DEC, 0);
        prog[3] = enc(I_JNZ, 4'd1); prog[4] = enc(I_HALT, 0);
        in_list[0] = 8'd3;
        run_prog("countdown", 1, 0, 1);

        // accumulator wrap both ways
        do_reset("dec");
        clear_prog();
        prog[0] = enc(I_LDI, 0); prog[1] = enc(I_DEC, 0); prog[2] = enc(I_OUT, 0);
        run_prog("dec_wrap", 1, 0, 0);
        do_reset("inc");
        clear_prog();
        prog[0] = enc(I_LDI, 0); prog[1] = enc(I_DEC, 0); prog[2] = enc(I_OUT, 0);
        prog[3] = enc(I_INC, 0); prog[4] = enc(I_OUT, 0);
        run_prog("inc_wrap", 1, 0, 1);

        // PC wrap 15 -> 0
        do_reset("wrap");
        clear_prog();
        prog[0]  = enc(I_JNZ, 4'd13); prog[1] = enc(I_LDI, 4'd5); prog[2] = enc(I_JMP, 4'd15);
        prog[15] = enc(I_INC, 0); prog[13] = enc(I_OUT, 0); prog[14] = enc(I_HALT, 0);
        run_prog("pc_wrap", 1, 0, 1);

        // OUT back-pressure, then reset while stalled in OUT
        for (int pass = 0; pass < 2; pass++) begin
            do_reset("bp");
            clear_prog();
            prog[0] = enc(I_LDI, 4'd9); prog[1] = enc(I_OUT, 0);
            load_prog();
            bus.out_ready = 1'b0;
            pulse_start();
            n = 0;
            while (!bus.out_valid && n < 20) begin @(negedge clk); #1; n++; end
            check_eq("bp:out_valid_seen", bus.out_valid, 1);
            if (pass == 0) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk); #1;
                    check_eq("bp:out_valid", bus.out_valid, 1);
                    check_eq("bp:out_data", bus.out_data, 9);
                    check_eq("bp:pc", pc, 2);
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
                @(negedge clk); #1;
                check_eq("bp:released", bus.out_valid, 0);
                bus.out_ready = 1'b0;
                n = 0;
                while (!halted && n < 20) begin @(negedge clk); #1; n++; end
                check_eq("bp:halted", halted, 1);
                check_eq("bp:out_hold", bus.out_data, 9);
            end else begin
                @(negedge clk);
                #2 reset = 1'b1;
                #1;
                check_eq("rst_out:out_valid", bus.out_valid, 0);
                check_eq("rst_out:halted", halted, 1);
                check_eq("rst_out:pc", pc, 0);
                @(negedge clk);
                reset = 1'b0;
            end
        end

        // prog_we during FETCH is ignored; rerun from unchanged memory confirms it
        do_reset("we");
        clear_prog();
        prog[0] = enc(I_LDI, 4'd3); prog[1] = enc(I_OUT, 0);
        run_prog("we_fetch", 1, 1, 0);
        do_reset("readback");
        run_prog("readback", 0, 0, 1);

        // randomized forward-branching programs
        for (int t = 0; t < 20; t++) begin
            do_reset("rnd");
            clear_prog();
            for (int i = 0; i < DEPTH - 1; i++) begin
                logic [2:0] op;
                logic [3:0] opd;
                op  = 3'($urandom_range(0, 7));
                opd = 4'($urandom);
                if (op == I_JNZ || op == I_JMP) opd = 4'($urandom_range(i + 1, DEPTH - 1));
                prog[i] = enc(op, opd);
            end
            run_prog("random", 1, 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
